// File: rtl/dsrlzr_sipo_sync.sv
// Serial-in/parallel-out receive stage with sync-word alignment.
// Hunts for SYNC_WORD in the MSB-first bit stream, then delivers FRAME_LEN
// payload words per frame with a one-cycle valid strobe. It rides through
// isolated sync errors and drops lock after MAX_MISS consecutive misses.
module dsrlzr_sipo_sync #(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD = 8'hA5,
    parameter int unsigned       FRAME_LEN = 4,
    parameter int unsigned       MAX_MISS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iSRL_IN,
    input  logic              iSRL_EN,
    input  logic              iRESYNC,
    output logic [DATA_W-1:0] oDATA,
    output logic              oVALID,
    output logic              oLOCK,
    output logic              oSYNC_ERR
);

    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FILL_W = $clog2(DATA_W + 1);
    localparam int WORD_W = $clog2(FRAME_LEN + 1);
    localparam int MISS_W = $clog2(MAX_MISS + 1);

    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(DATA_W);
    localparam logic [WORD_W-1:0] WORD_SYNC  = WORD_W'(FRAME_LEN);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISS);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e              state_q,    state_d;
    logic [DATA_W-1:0]   sr_q,       sr_d;
    logic [FILL_W-1:0]   fill_q,     fill_d;
    logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic                valid_q,    valid_d;
    logic                sync_err_q, sync_err_d;

    // Shift-register contents after accepting the current serial bit.
    logic [DATA_W-1:0] nxt;
    logic [MISS_W-1:0] miss_inc;

    assign nxt      = {sr_q[DATA_W-2:0], iSRL_IN};
    assign miss_inc = miss_cnt_q + 1'b1;

    // Next-state logic: resync override, hunt for alignment, framed delivery.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d    = state_q;
        sr_d       = sr_q;
        fill_d     = fill_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        miss_cnt_d = miss_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;

        if (iRESYNC) begin
            // The bit presented on this edge is discarded; oDATA holds.
            state_d    = ST_HUNT;
            sr_d       = '0;
            fill_d     = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            miss_cnt_d = '0;
        end else if (iSRL_EN) begin
            sr_d = nxt;
            unique case (state_q)
                ST_HUNT: begin
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 1'b1;
                    end
                    // Only compare once a full word of fresh bits has arrived.
                    if ((fill_d == FILL_FULL) && (nxt == SYNC_WORD)) begin
                        state_d    = ST_LOCKED;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        miss_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q < WORD_SYNC) begin
                            // Payload slot: a sync-pattern payload is plain data.
                            data_d     = nxt;
                            valid_d    = 1'b1;
                            word_cnt_d = word_cnt_q + 1'b1;
                        end else begin
                            word_cnt_d = '0;
                            if (nxt == SYNC_WORD) begin
                                miss_cnt_d = '0;
                            end else begin
                                sync_err_d = 1'b1;
                                if (miss_inc == MISS_LIMIT) begin
                                    // Lock lost: a fresh full word is needed to relock.
                                    state_d    = ST_HUNT;
                                    fill_d     = '0;
                                    bit_cnt_d  = '0;
                                    word_cnt_d = '0;
                                    miss_cnt_d = '0;
                                end else begin
                                    miss_cnt_d = miss_inc;
                                end
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HUNT;
            sr_q       <= '0;
            fill_q     <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            miss_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q    <= state_d;
            sr_q       <= sr_d;
            fill_q     <= fill_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign oDATA     = data_q;
    assign oVALID    = valid_q;
    assign oLOCK     = (state_q == ST_LOCKED);
    assign oSYNC_ERR = sync_err_q;

endmodule

// File: doc/dsrlzr_sipo_sync.md
Name: dsrlzr_sipo_sync

Overview:
Serial-in/parallel-out receive stage, directly downstream of the PISO serializer.
- Consumes the serial bit stream MSB-first, one bit per clk with enable.
- Hunts for a sync word and aligns to it.
- Once aligned, delivers fixed-length frames of payload words with a one-cycle valid strobe.
- Keeps lock through isolated sync errors (flywheel) and drops lock after consecutive misses.

Parameters:
DATA_W, 8, word width in bits; also the serial bits per word.
SYNC_WORD, 8'hA5, alignment pattern (DATA_W bits, non-zero).
FRAME_LEN, 4, payload words between sync words (>=1).
MAX_MISS, 2, consecutive missed sync slots that cause loss of lock (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  reset, asynchronous assert, active-low; all state cleared while low.
iSRL_IN  input  1  serial data bit, MSB of each word first.
iSRL_EN  input  1  bit strobe; iSRL_IN is sampled only on edges where this is 1.
iRESYNC  input  1  synchronous force-to-HUNT request.
oDATA  output  DATA_W  received payload word, held between strobes.
oVALID  output  1  one-cycle strobe; oDATA is new.
oLOCK  output  1  1 while in LOCKED.
oSYNC_ERR  output  1  one-cycle pulse on each missed sync slot while locked.

Behaviour:
- Reset (rst=0, asynchronous):
  - oDATA=0, oVALID=0, oLOCK=0, oSYNC_ERR=0.
  - State HUNT; shift register, fill, bit, word and miss counters all 0.
- Shift: on an edge with iSRL_EN=1, sr <= {sr[DATA_W-2:0], iSRL_IN}. "nxt" is that new value.
- iSRL_EN=0: nothing changes except oVALID and oSYNC_ERR, which return to 0.
- oVALID and oSYNC_ERR:
  - Registered, default 0 every cycle.
  - High for exactly one cycle after the edge that samples the last bit of a word.
- Priority per edge: iRESYNC > normal operation.
- iRESYNC=1:
  - State HUNT, oLOCK=0, sr=0; fill, bit, word and miss counters = 0.
  - oVALID=0, oSYNC_ERR=0. oDATA holds.
  - The bit on iSRL_IN that edge is discarded.
- HUNT:
  - fill counts accepted bits and saturates at DATA_W.
  - Compare runs on every accepted bit once the bit just accepted brings fill to DATA_W (i.e. at least DATA_W fresh bits since reset/resync).
  - On nxt==SYNC_WORD: go to LOCKED, oLOCK=1, bit_cnt=0, word_cnt=0, miss_cnt=0.
  - No oVALID during HUNT.
- LOCKED:
  - bit_cnt increments per accepted bit and wraps DATA_W-1 -> 0. The wrap edge is word-complete.
  - Payload slot (word_cnt < FRAME_LEN), on word-complete:
    - oDATA <= nxt, oVALID=1, word_cnt++.
    - A payload equal to SYNC_WORD is ordinary data; no realignment.
  - Sync slot (word_cnt == FRAME_LEN), on word-complete:
    - word_cnt <= 0; no oVALID.
    - nxt==SYNC_WORD: miss_cnt <= 0.
    - Mismatch: oSYNC_ERR=1 and miss_cnt++.
    - If the incremented miss_cnt reaches MAX_MISS: state HUNT, oLOCK=0, fill=0, counters cleared. The next lock needs DATA_W fresh bits.
    - Otherwise stay LOCKED; the next frame's payload is still delivered.
- No back-pressure: the consumer must accept every oVALID strobe.
- Counter widths: bit_cnt ceil(log2(DATA_W)); word_cnt ceil(log2(FRAME_LEN+1)); miss_cnt ceil(log2(MAX_MISS+1)). No overflow is possible.

Test Plan:
1. Reset mid-word: iSRL_EN=1 streaming, drop rst for 3 ns between edges -> all outputs 0 immediately; after release, HUNT with fill=0.
2. Lock and deliver: iSRL_EN=1 continuous, bits A5,11,22,33,44,A5,55 MSB-first -> oLOCK=1 after the 8th bit; oVALID pulses 11,22,33,44 spaced 8 cycles apart; no pulse for either A5; 55 delivered.
3. Stalled input: same stream as scenario 2 with iSRL_EN randomly 0 for 0-5 cycles between bits -> identical oDATA sequence, one oVALID per word, no extra pulses.
4. Flywheel and loss of lock:
   - First sync slot 00 -> single oSYNC_ERR pulse, oLOCK stays 1, next 4 payloads delivered.
   - Second consecutive sync slot 00 -> oSYNC_ERR pulse and oLOCK=0 on the same edge; no oVALID until A5 plus 8 bits are re-seen.
5. Sync pattern in payload: locked, payload word A5 -> oDATA=A5 with oVALID, alignment and word_cnt unchanged.
6. Resync:
   - iRESYNC=1 mid-frame -> oLOCK=0 next edge.
   - Feed the 3 bits that would complete A5 with the old sr contents -> no lock.
   - Full 8-bit A5 -> lock.
